// File: rtl/pc_im.sv
// Program counter with a combinational incrementer and an instruction memory that
// reads asynchronously at the current PC and writes synchronously at the pre-edge PC.
module pc_im #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          branch,
  input  logic          stall,
  input  logic [AW-1:0] br_address,
  input  logic          en_write,
  input  logic [DW-1:0] data_in,
  output logic [AW-1:0] instr_address,
  output logic [AW-1:0] pc_plus1,
  output logic [DW-1:0] data_out
);

  localparam int DEPTH = 1 << AW;

  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_next;

  // Power-up contents are zero; the array is never reset so it survives reset pulses.
  logic [DW-1:0] mem [0:DEPTH-1] = '{default: '0};

  // Wraps naturally at the top of the address space.
  assign pc_plus1 = pc_q + AW'(1);

  // Stall outranks branch; a branch to the current PC simply holds it.
  always_comb begin
    pc_next = pc_plus1;
    if (stall) begin
      pc_next = pc_q;
    end else if (branch) begin
      pc_next = br_address;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_next;
    end
  end

  // Write uses the address held before the edge, so it lands at address 0 during reset.
  always_ff @(posedge clk) begin
    if (en_write) begin
      mem[pc_q] <= data_in;
    end
  end

  assign instr_address = pc_q;
  assign data_out      = mem[pc_q];

endmodule

// File: tb/tb_pc_im.sv
// Directed bench for pc_im: reset, free-run, memory write/readback, branch, stall,
// wrap-around and asynchronous reset behaviour.
module tb_pc_im;

  logic        clk = 1'b0;
  logic        reset;
  logic        branch;
  logic        stall;
  logic [9:0]  br_address;
  logic        en_write;
  logic [15:0] data_in;
  logic [9:0]  instr_address;
  logic [9:0]  pc_plus1;
  logic [15:0] data_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [9:0] exp_q[$];

  pc_im dut (
    .clk           (clk),
    .reset         (reset),
    .branch        (branch),
    .stall         (stall),
    .br_address    (br_address),
    .en_write      (en_write),
    .data_in       (data_in),
    .instr_address (instr_address),
    .pc_plus1      (pc_plus1),
    .data_out      (data_out)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Driver tasks: inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b1;
    #1 reset = 1'b0;
  endtask

  task automatic idle_inputs();
    branch     = 1'b0;
    stall      = 1'b0;
    br_address = '0;
    en_write   = 1'b0;
    data_in    = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    #2;
    n_cmp++;
    if (instr_address !== 10'h000) begin
      n_bad++; $display("FAIL reset_pc got %h want 000", instr_address);
    end
    n_cmp++;
    if (pc_plus1 !== 10'h001) begin
      n_bad++; $display("FAIL reset_pc_plus1 got %h want 001", pc_plus1);
    end
    n_cmp++;
    if (data_out !== 16'h0000) begin
      n_bad++; $display("FAIL reset_data_out got %h want 0000", data_out);
    end
    tick();
    n_cmp++;
    if (instr_address !== 10'h000) begin
      n_bad++; $display("FAIL reset_held_over_edge got %h want 000", instr_address);
    end
    reset = 1'b0;
  endtask

  task automatic test_free_run();
    logic [9:0] exp_a;
    for (int i = 0; i <= 5; i++) exp_q.push_back(10'(i));
    exp_a = exp_q.pop_front();
    n_cmp++;
    if (instr_address !== exp_a) begin
      n_bad++; $display("FAIL free_run_start got %h want %h", instr_address, exp_a);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_a = exp_q.pop_front();
      n_cmp++;
      if (instr_address !== exp_a) begin
        n_bad++; $display("FAIL free_run_pc got %h want %h", instr_address, exp_a);
      end
      n_cmp++;
      if (pc_plus1 !== exp_a + 10'd1) begin
        n_bad++; $display("FAIL free_run_pc_plus1 got %h want %h", pc_plus1, exp_a + 10'd1);
      end
    end
  endtask

  task automatic test_write_readback();
    pulse_reset();
    en_write = 1'b1;
    data_in  = 16'h0011;
    repeat (4) tick();
    n_cmp++;
    if (instr_address !== 10'h004) begin
      n_bad++; $display("FAIL write_pc_advance got %h want 004", instr_address);
    end
    en_write = 1'b0;
    data_in  = 16'hFFFF;
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (data_out !== ((i < 4) ? 16'h0011 : 16'h0000)) begin
        n_bad++; $display("FAIL readback_data pc %0d got %h want %h", i, data_out,
                          (i < 4) ? 16'h0011 : 16'h0000);
      end
      tick();
    end
  endtask

  task automatic test_branch();
    pulse_reset();
    repeat (3) tick();
    n_cmp++;
    if (instr_address !== 10'h003) begin
      n_bad++; $display("FAIL branch_setup got %h want 003", instr_address);
    end
    branch = 1'b1; br_address = 10'h200;
    tick();
    n_cmp++;
    if (instr_address !== 10'h200) begin
      n_bad++; $display("FAIL branch_taken got %h want 200", instr_address);
    end
    branch = 1'b0;
    tick();
    n_cmp++;
    if (instr_address !== 10'h201) begin
      n_bad++; $display("FAIL branch_next got %h want 201", instr_address);
    end
    branch = 1'b1; br_address = 10'h201;
    tick();
    n_cmp++;
    if (instr_address !== 10'h201) begin
      n_bad++; $display("FAIL branch_self got %h want 201", instr_address);
    end
    branch = 1'b0;
  endtask

  task automatic test_stall_priority();
    stall = 1'b1; branch = 1'b1; br_address = 10'h055;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (instr_address !== 10'h201) begin
        n_bad++; $display("FAIL stall_hold edge %0d got %h want 201", i, instr_address);
      end
    end
    stall = 1'b0;
    tick();
    n_cmp++;
    if (instr_address !== 10'h055) begin
      n_bad++; $display("FAIL stall_release got %h want 055", instr_address);
    end
    branch = 1'b0;
  endtask

  task automatic test_stall_write();
    stall = 1'b1; en_write = 1'b1; data_in = 16'hA5A5;
    n_cmp++;
    if (data_out !== 16'h0000) begin
      n_bad++; $display("FAIL stall_write_before got %h want 0000", data_out);
    end
    tick();
    n_cmp++;
    if (data_out !== 16'hA5A5 || instr_address !== 10'h055) begin
      n_bad++; $display("FAIL stall_write_after got %h@%h want a5a5@055", data_out, instr_address);
    end
    stall = 1'b0; en_write = 1'b0;
    // Write and PC advance on the same edge: new PC shows its own (zero) word.
    en_write = 1'b1; data_in = 16'h1234;
    tick();
    en_write = 1'b0;
    n_cmp++;
    if (instr_address !== 10'h056 || data_out !== 16'h0000) begin
      n_bad++; $display("FAIL write_and_advance got %h@%h want 0000@056", data_out, instr_address);
    end
    branch = 1'b1; br_address = 10'h055;
    tick();
    branch = 1'b0;
    n_cmp++;
    if (data_out !== 16'h1234) begin
      n_bad++; $display("FAIL write_pre_edge_addr got %h want 1234", data_out);
    end
  endtask

  task automatic test_wrap();
    branch = 1'b1; br_address = 10'h3FF;
    tick();
    branch = 1'b0;
    n_cmp++;
    if (pc_plus1 !== 10'h000) begin
      n_bad++; $display("FAIL wrap_pc_plus1 got %h want 000", pc_plus1);
    end
    tick();
    n_cmp++;
    if (instr_address !== 10'h000) begin
      n_bad++; $display("FAIL wrap_pc got %h want 000", instr_address);
    end
  endtask

  task automatic test_async_reset();
    branch = 1'b1; br_address = 10'h123;
    tick();
    branch = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (instr_address !== 10'h000) begin
      n_bad++; $display("FAIL async_reset_pc got %h want 000", instr_address);
    end
    n_cmp++;
    if (data_out !== 16'h0011) begin
      n_bad++; $display("FAIL async_reset_mem got %h want 0011", data_out);
    end
    en_write = 1'b1; data_in = 16'hBEEF;
    tick();
    en_write = 1'b0;
    n_cmp++;
    if (instr_address !== 10'h000 || data_out !== 16'hBEEF) begin
      n_bad++; $display("FAIL write_in_reset got %h@%h want beef@000", data_out, instr_address);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (instr_address !== 10'h001 || data_out !== 16'h0011) begin
      n_bad++; $display("FAIL after_reset got %h@%h want 0011@001", data_out, instr_address);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_write_readback();
    test_branch();
    test_stall_priority();
    test_stall_write();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
